mem_dump_uart: RTL and testbench
================================

Name: mem_dump_uart

Overview:
- Hardware readout engine for the RISC-V SoC. It lets the data memory contents left by a program be checked on a board, where no simulation waveform or memory peek is available.
- When triggered, it reads a range of 32-bit words from a synchronous-read memory port, one word at a time.
- Each word is serialized as 4 bytes, little-endian, over an 8N1 UART transmit line.
- It sits beside the data RAM on a second read port, and is driven by a debug button or the test-control logic.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate.
- BAUD_DIV, CLK_FREQ/BAUD (434), clock cycles per UART bit. Derived; must be 2 or more.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high (`RstEnable = 1).
- start_i  input  1  single-cycle start request; sampled only in IDLE.
- base_addr_i  input  32  byte address of the first word. Bits [1:0] are ignored and treated as 0.
- word_cnt_i  input  16  number of words to dump; 0 is allowed.
- mem_re_o  output  1  memory read enable, one-cycle pulse per word.
- mem_addr_o  output  32  memory read byte address, word-aligned.
- mem_data_i  input  32  read data, valid on the cycle after mem_re_o.
- tx_o  output  1  UART serial output; idles high.
- busy_o  output  1  high from start acceptance until the done cycle, inclusive.
- done_o  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset values: tx_o=1, mem_re_o=0, mem_addr_o=0, busy_o=0, done_o=0, FSM=IDLE, all counters 0. Reset applies asynchronously at any point, including mid-bit; tx_o returns high immediately.
- IDLE:
  - start_i=1: latch base_addr_i with bits [1:0] cleared, latch word_cnt_i, set busy_o=1.
  - If the latched count is 0, go to DONE (no reads, no bytes). Otherwise go to READ.
- READ: drive mem_re_o=1 and mem_addr_o=current address for exactly 1 cycle, then go to CAPTURE.
- CAPTURE: register mem_data_i into a 32-bit word buffer, set byte index=0, go to TX.
- TX: send byte buffer[8*idx+7 : 8*idx].
  - Frame: start bit 0, 8 data bits LSB first, stop bit 1.
  - Each bit is held exactly BAUD_DIV cycles; the bit counter reloads on every bit boundary.
  - One frame = 10*BAUD_DIV cycles. Frames are back-to-back with no extra idle gap.
- After stop bit:
  - idx<3: idx+1, send the next byte.
  - idx==3: decrement the remaining count and add 4 to the address (modulo 2^32; 0xFFFFFFFC wraps to 0x00000000).
  - Remaining count nonzero: go to READ. Zero: go to CSUM if the optional feature is compiled in, else DONE.
- DONE: done_o=1 and busy_o=1 for one cycle, then IDLE with busy_o=0.
- start_i while not in IDLE: ignored, not queued. start_i during the DONE cycle: ignored.
- Input changes after acceptance do not affect the dump in progress.
- mem_addr_o holds its last value when mem_re_o=0.
- Gap between words: 2 cycles (READ, CAPTURE) at tx_o=1 between the stop bit of byte 3 and the start bit of the next word.
- Full dump of N words: N*(40*BAUD_DIV+2) cycles from acceptance to DONE, without checksum.

Optional Feature:
- Macro: MEM_DUMP_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR of every transmitted data byte is kept; it is cleared on start acceptance.
  - After the last word, state CSUM transmits that XOR as one extra 8N1 frame, then goes to DONE.
  - When word_cnt is 0, no checksum byte is sent.
- Not defined: no checksum logic and no CSUM state; the stream is only the data bytes.

Test Plan:
- Reset mid-frame: assert rst during bit 4 of the first byte -> same cycle tx_o=1 and busy_o=0; no done_o pulse follows.
- Single word: memory[0x100]=0x12345678, base=0x100, cnt=1, start -> one mem_re_o pulse with mem_addr_o=0x100; bytes 0x78,0x56,0x34,0x12 decoded LSB-first, each bit 434 cycles; done_o pulses once 40*434+2 cycles after acceptance.
- Multi-word, unaligned base: base=0x203, cnt=3 -> reads at 0x200, 0x204, 0x208; 12 bytes in order; exactly 3 mem_re_o pulses.
- Zero count and ignored start: cnt=0 -> done_o 1 cycle after acceptance, tx_o stays high; a second start_i while busy during a 2-word dump -> still exactly 8 bytes and 1 done_o.
- Address wrap: base=0xFFFFFFFC, cnt=2 -> reads at 0xFFFFFFFC then 0x00000000.
- Checksum (MEM_DUMP_CHECKSUM_EN): word 0x12345678 -> 5th byte 0x08 (0x78^0x56^0x34^0x12); without the macro, only 4 bytes.

Source files
------------

// File: rtl/mem_dump_if.sv
// mem_dump_if: trigger, memory read port and UART/status signals of the memory dump engine
interface mem_dump_if;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [15:0] word_cnt_i;
    logic        mem_re_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_i;
    logic        tx_o;
    logic        busy_o;
    logic        done_o;

    modport slave (
        input  start_i, base_addr_i, word_cnt_i, mem_data_i,
        output mem_re_o, mem_addr_o, tx_o, busy_o, done_o
    );

    modport master (
        output start_i, base_addr_i, word_cnt_i, mem_data_i,
        input  mem_re_o, mem_addr_o, tx_o, busy_o, done_o
    );
endinterface

// File: rtl/mem_dump_uart.sv
// mem_dump_uart: reads a range of 32-bit words and sends them little-endian over an 8N1 UART (MEM_DUMP_CHECKSUM_EN appends an XOR checksum byte)
module mem_dump_uart #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
    input  logic      clk,
    input  logic      rst,
    mem_dump_if.slave bus
);
    localparam int            BW       = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_MAX = BW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, READ, CAPTURE, TX,
`ifdef MEM_DUMP_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

    state_t        state_q;
    logic [31:0]   addr_q;
    logic [15:0]   cnt_q;
    logic [31:0]   buf_q;
    logic [1:0]    idx_q;
    logic [3:0]    bit_q;
    logic [BW-1:0] baud_q;
    logic [8:0]    frame_q;
    logic          tx_q;
    logic          mem_re_q;
    logic [31:0]   mem_addr_q;
    logic          busy_q;
    logic          done_q;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [7:0]    csum_q;
`endif

    logic [31:0] base_al;
    logic [31:0] addr_nxt;

    assign base_al  = bus.base_addr_i & ~32'h3;
    assign addr_nxt = addr_q + 32'd4;

    assign bus.tx_o       = tx_q;
    assign bus.mem_re_o   = mem_re_q;
    assign bus.mem_addr_o = mem_addr_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;

    // Sequencer: fetch a word, shift its four bytes out frame by frame, repeat until the count runs out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            idx_q      <= '0;
            bit_q      <= '0;
            baud_q     <= '0;
            frame_q    <= '0;
            tx_q       <= 1'b1;
            mem_re_q   <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            mem_re_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: if (bus.start_i) begin
                    addr_q <= base_al;
                    cnt_q  <= bus.word_cnt_i;
                    busy_q <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
                    csum_q <= '0;
`endif
                    if (bus.word_cnt_i == 16'd0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= READ;
                        mem_re_q   <= 1'b1;
                        mem_addr_q <= base_al;
                    end
                end
                READ: state_q <= CAPTURE;
                CAPTURE: begin
                    buf_q   <= bus.mem_data_i;
                    idx_q   <= '0;
                    tx_q    <= 1'b0;
                    frame_q <= {1'b1, bus.mem_data_i[7:0]};
                    bit_q   <= '0;
                    baud_q  <= '0;
                    state_q <= TX;
`ifdef MEM_DUMP_CHECKSUM_EN
                    csum_q  <= csum_q ^ bus.mem_data_i[7:0] ^ bus.mem_data_i[15:8]
                             ^ bus.mem_data_i[23:16] ^ bus.mem_data_i[31:24];
`endif
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                // TX and CSUM share the bit engine; frame_q holds the data bits still to go plus the stop bit
                default: begin
                    if (baud_q != BAUD_MAX) begin
                        baud_q <= baud_q + BW'(1);
                    end else begin
                        baud_q <= '0;
                        if (bit_q != 4'd9) begin
                            tx_q    <= frame_q[0];
                            frame_q <= {1'b1, frame_q[8:1]};
                            bit_q   <= bit_q + 4'd1;
                        end else if (state_q == TX && idx_q != 2'd3) begin
                            idx_q   <= idx_q + 2'd1;
                            buf_q   <= {8'h00, buf_q[31:8]};
                            tx_q    <= 1'b0;
                            frame_q <= {1'b1, buf_q[15:8]};
                            bit_q   <= '0;
                        end else if (state_q == TX && cnt_q != 16'd1) begin
                            cnt_q      <= cnt_q - 16'd1;
                            addr_q     <= addr_nxt;
                            mem_addr_q <= addr_nxt;
                            mem_re_q   <= 1'b1;
                            state_q    <= READ;
                        end
`ifdef MEM_DUMP_CHECKSUM_EN
                        else if (state_q == TX) begin
                            cnt_q   <= cnt_q - 16'd1;
                            addr_q  <= addr_nxt;
                            tx_q    <= 1'b0;
                            frame_q <= {1'b1, csum_q};
                            bit_q   <= '0;
                            state_q <= CSUM;
                        end
`endif
                        else begin
                            if (state_q == TX) begin
                                cnt_q  <= cnt_q - 16'd1;
                                addr_q <= addr_nxt;
                            end
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_dump_uart.sv
// tb_mem_dump_uart: directed table-driven bench for mem_dump_uart with a UART byte decoder and a read-port model
module tb_mem_dump_uart;
    localparam int D     = 4;
    localparam int LIMIT = 2000;
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    typedef struct {
        logic [31:0] base;
        logic [15:0] cnt;
        int          restart_at;
        logic [31:0] a_first;
        logic [31:0] a_last;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    mem_dump_if bus();

    mem_dump_uart #(.CLK_FREQ(1000), .BAUD(250)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int frame_err = 0;
    logic [7:0]  rx_q[$];
    logic [31:0] rd_q[$];
    logic [7:0]  mon_b;
    logic        mon_s;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h1234_5678;
        if (a == 32'h0000_0300) return 32'h0000_0000;
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    always @(posedge clk) if (bus.mem_re_o) bus.mem_data_i <= mem_f(bus.mem_addr_o);

    always @(negedge clk) begin
        if (bus.done_o) done_cnt++;
        if (bus.mem_re_o) rd_q.push_back(bus.mem_addr_o);
    end

    initial forever begin
        @(negedge clk);
        if (bus.tx_o === 1'b0) begin
            repeat (D / 2) @(negedge clk);
            mon_s = bus.tx_o;
            for (int j = 0; j < 8; j++) begin
                repeat (D) @(negedge clk);
                mon_b[j] = bus.tx_o;
            end
            repeat (D) @(negedge clk);
            if (mon_s !== 1'b0 || bus.tx_o !== 1'b1) frame_err++;
            rx_q.push_back(mon_b);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_dump(input logic [31:0] b, input logic [15:0] c);
        @(negedge clk);
        bus.start_i     = 1'b1;
        bus.base_addr_i = b;
        bus.word_cnt_i  = c;
        @(negedge clk);
        bus.start_i     = 1'b0;
        bus.base_addr_i = 32'hDEAD_BEE0;
        bus.word_cnt_i  = 16'd7;
    endtask

    vec_t        tv [5];
    vec_t        v;
    int          k;
    int          mism;
    logic [7:0]  eb[$];
    logic [7:0]  cs;
    logic [31:0] d;
    logic [31:0] a;

    initial begin
        tv[0] = '{32'h0000_0100, 16'd1, 0,  32'h0000_0100, 32'h0000_0100, 163};
        tv[1] = '{32'h0000_0203, 16'd3, 0,  32'h0000_0200, 32'h0000_0208, 487};
        tv[2] = '{32'h0000_0050, 16'd0, 1,  32'h0000_0000, 32'h0000_0000, 1};
        tv[3] = '{32'h0000_0400, 16'd2, 50, 32'h0000_0400, 32'h0000_0404, 325};
        tv[4] = '{32'hFFFF_FFFC, 16'd2, 0,  32'hFFFF_FFFC, 32'h0000_0000, 325};

        bus.start_i     = 1'b0;
        bus.base_addr_i = '0;
        bus.word_cnt_i  = '0;
        repeat (2) @(negedge clk);
        check("rst_tx", bus.tx_o, 1);
        check("rst_mem_re", bus.mem_re_o, 0);
        check("rst_mem_addr", bus.mem_addr_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_done", bus.done_o, 0);
        rst = 1'b0;

        // reset in the middle of data bit 4 of an all-zero byte
        done_cnt = 0;
        start_dump(32'h0000_0300, 16'd1);
        repeat (24) @(negedge clk);
        check("midframe_tx_low", bus.tx_o, 0);
        rst = 1'b1;
        #1;
        check("midframe_rst_tx", bus.tx_o, 1);
        check("midframe_rst_busy", bus.busy_o, 0);
        check("midframe_rst_mem_re", bus.mem_re_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("midframe_no_done", done_cnt, 0);
        check("midframe_idle_tx", bus.tx_o, 1);
        rx_q.delete();
        frame_err = 0;

        // single word with hand-decoded byte values
        done_cnt = 0;
        start_dump(32'h0000_0100, 16'd1);
        k = 1;
        while (!bus.done_o && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        repeat (4 * D) @(negedge clk);
        check("single_nbytes", rx_q.size(), 4 + CS);
        check("single_b0", rx_q[0], 8'h78);
        check("single_b1", rx_q[1], 8'h56);
        check("single_b2", rx_q[2], 8'h34);
        check("single_b3", rx_q[3], 8'h12);
`ifdef MEM_DUMP_CHECKSUM_EN
        check("single_csum", rx_q[4], 8'h08);
`endif
        rx_q.delete();
        rd_q.delete();

        for (int i = 0; i < 5; i++) begin
            v = tv[i];
            rx_q.delete();
            rd_q.delete();
            done_cnt  = 0;
            frame_err = 0;
            start_dump(v.base, v.cnt);
            check($sformatf("v%0d_busy_start", i), bus.busy_o, 1);
            k = 1;
            forever begin
                bus.start_i = (k == v.restart_at);
                if (bus.done_o || k >= LIMIT) break;
                @(negedge clk);
                k++;
            end
            check($sformatf("v%0d_done_latency", i), k, v.lat + ((v.cnt != 0) ? CS * 10 * D : 0));
            @(negedge clk);
            bus.start_i = 1'b0;
            check($sformatf("v%0d_busy_after", i), bus.busy_o, 0);
            repeat (4 * D) @(negedge clk);
            check($sformatf("v%0d_done_count", i), done_cnt, 1);
            check($sformatf("v%0d_reads", i), rd_q.size(), v.cnt);
            check($sformatf("v%0d_tx_idle", i), bus.tx_o, 1);
            check($sformatf("v%0d_frame_err", i), frame_err, 0);
            if (v.cnt != 0) begin
                check($sformatf("v%0d_addr_first", i), rd_q[0], v.a_first);
                check($sformatf("v%0d_addr_last", i), rd_q[rd_q.size() - 1], v.a_last);
            end
            eb.delete();
            cs   = '0;
            mism = 0;
            for (int w = 0; w < int'(v.cnt); w++) begin
                a = (v.base & ~32'h3) + 32'(4 * w);
                if (w >= rd_q.size() || rd_q[w] !== a) mism++;
                d = mem_f(a);
                for (int b = 0; b < 4; b++) begin
                    eb.push_back(d[8*b +: 8]);
                    cs ^= d[8*b +: 8];
                end
            end
            if (CS != 0 && v.cnt != 0) eb.push_back(cs);
            check($sformatf("v%0d_addr_seq_errs", i), mism, 0);
            check($sformatf("v%0d_nbytes", i), rx_q.size(), eb.size());
            mism = 0;
            for (int j = 0; j < eb.size(); j++)
                if (j >= rx_q.size() || rx_q[j] !== eb[j]) mism++;
            check($sformatf("v%0d_byte_errs", i), mism, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
